mtrx_slice_fifo_arb: RTL and testbench
======================================

// Module: mtrx_slice_fifo_arb
// PURPOSE
//  Round-robin scheduler sharing one Mtrx_slice_fifo (64b write, 8b read, width-converting) among NUM_REQ
//  matrix-slice producers. Grants whole bursts only when credit guarantees space, so the FIFO never sees
//  a write while full. Drives the FIFO read port for a single byte consumer and tags each byte with
//  the source id and an end-of-burst flag.
// PARAMETERS
//  NUM_REQ     4   number of requesters
//  WR_WIDTH    64  FIFO write width (bits)
//  RD_WIDTH    8   FIFO read width; RATIO = WR_WIDTH/RD_WIDTH = 8
//  FIFO_DEPTH  16  FIFO capacity in WR_WIDTH words
//  BURST_LEN   4   words per grant; FIFO_DEPTH % BURST_LEN == 0
//  ID_W        2   $clog2(NUM_REQ)
// PORTS
//  s_clk        in   1                 clock
//  s_rst        in   1                 synchronous active-high reset, also tied to FIFO srst
//  req_valid    in   NUM_REQ           requester i holds a full burst ready
//  req_data     in   NUM_REQ*WR_WIDTH  requester i word at [i*WR_WIDTH +: WR_WIDTH]
//  grant        out  NUM_REQ           one-hot; high = winner's req_data sampled this cycle
//  fifo_din     out  WR_WIDTH          to FIFO din
//  fifo_wr_en   out  1                 to FIFO wr_en
//  fifo_full    in   1                 from FIFO
//  fifo_empty   in   1                 from FIFO
//  fifo_rd_en   out  1                 to FIFO rd_en
//  fifo_dout    in   RD_WIDTH          from FIFO (valid 1 cycle after rd_en)
//  cons_rd_en   in   1                 consumer requests one byte
//  cons_valid   out  1                 cons_data valid this cycle
//  cons_data    out  RD_WIDTH          byte
//  cons_src_id  out  ID_W              requester that wrote cons_data
//  cons_last    out  1                 cons_data is the last byte of its burst
//  err_overflow out  1                 sticky: fifo_wr_en while fifo_full
// BEHAVIOUR
//  - Reset: grant=0, fifo_wr_en=0, fifo_rd_en=0, cons_*=0, err_overflow=0, rr_ptr=0, credit=FIFO_DEPTH,
//    beat=0, byte counters=0, tag queue empty, FSM=IDLE. Reset mid-burst aborts the burst; nothing is kept.
//  - FSM IDLE: if |req_valid && credit>=BURST_LEN: winner = first set req_valid at or after rr_ptr (cyclic),
//    rr_ptr<=winner+1 (mod NUM_REQ), credit-=BURST_LEN, push winner to tag queue, beat<=0, ->BURST.
//    Otherwise stay IDLE.
//  - BURST: grant=onehot(winner), fifo_wr_en=1, fifo_din=req_data[winner] (combinational from registered
//    winner). beat++; at beat==BURST_LEN-1 ->IDLE. Exactly BURST_LEN consecutive write cycles, then 1 IDLE
//    cycle. req_valid is ignored inside BURST (producer contract).
//  - Read: fifo_rd_en = cons_rd_en & ~fifo_empty (combinational). Read on empty is dropped, with no state
//    change. cons_valid, cons_data=fifo_dout, cons_src_id=tag head, cons_last are registered 1 cycle after
//    the accepted rd_en. Byte order per FIFO: din[63:56] first.
//  - byte_cnt (0..RATIO-1) per accepted read; on wrap credit+=1. burst_byte_cnt (0..BURST_LEN*RATIO-1);
//    its terminal value sets cons_last and pops the tag queue.
//  - Same-cycle reserve (-BURST_LEN) and release (+1): apply both (net). credit never exceeds FIFO_DEPTH.
//  - err_overflow sets if fifo_wr_en&&fifo_full. It is cleared only by s_rst, and the write is not suppressed.
// STRUCTURE
//  - Shared include (hyper_para.v style): RATIO, BURST_LEN, FIFO_DEPTH, ID_W, FSM state encodings.
//  - Sub-module slice_tag_fifo: sync FIFO, width ID_W, depth FIFO_DEPTH/BURST_LEN, show-ahead head output.
//    Push at grant and pop at last byte can occur in the same cycle.
//  - Remaining logic is one module: RR picker, FSM, credit/byte counters, output regs.
// TESTING
//  1 req_valid=4'b0001, data 64'h0000_0000_1234_5678 -> grant=0001 and fifo_wr_en for 4 cycles. 32 reads
//    give 00,00,00,00,12,34,56,78 x4, src_id=0, cons_last only on byte 32.
//  2 req_valid=4'b1111 held, no reads -> bursts granted to 0,1,2,3 with 1 idle cycle between them.
//    Then credit=0 and no grant. After 32 byte reads the next grant goes to req 0.
//  3 Fill to credit=4, then read 8th byte of a word in the same cycle a grant starts -> credit=1 after.
//  4 s_rst high at beat 2 of a burst -> next cycle grant=0, fifo_wr_en=0, credit=16, rr_ptr=0, cons_valid=0.
//  5 cons_rd_en=1 with fifo_empty=1 -> fifo_rd_en=0, cons_valid stays 0, counters unchanged.
//  6 Force fifo_full=1 during a burst write -> err_overflow=1 next cycle, stays 1 until s_rst.

Source files
------------

// File: rtl/mtrx_slice_fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtrx_slice_fifo_arb_pkg
// Description : Shared constants and FSM state encoding for the matrix-slice
//               FIFO arbiter and its tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mtrx_slice_fifo_arb_pkg;

    localparam int c_NUM_REQ    = 4;
    localparam int c_WR_WIDTH   = 64;
    localparam int c_RD_WIDTH   = 8;
    localparam int c_RATIO      = c_WR_WIDTH / c_RD_WIDTH;
    localparam int c_FIFO_DEPTH = 16;
    localparam int c_BURST_LEN  = 4;
    localparam int c_ID_W       = 2;
    // At most this many bursts can be resident in the data FIFO at once.
    localparam int c_TAG_DEPTH  = c_FIFO_DEPTH / c_BURST_LEN;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

endpackage : mtrx_slice_fifo_arb_pkg
`default_nettype wire

// File: rtl/mtrx_slice_fifo_arb_slice_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : slice_tag_fifo
// Description : Small synchronous FIFO holding the source id of every granted
//               burst still resident in the data FIFO. Show-ahead: o_head is
//               the oldest entry without a read strobe. Push and pop may
//               happen in the same cycle, including when full.
// Ports       : clk, rst (sync, active high)
//               i_push / i_din  - enqueue one id
//               i_pop           - discard the head entry
//               o_head          - oldest stored id
// Revision    : 1.0 - initial release
// ============================================================================
module slice_tag_fifo
    import mtrx_slice_fifo_arb_pkg::*;
#(
    parameter int WIDTH = c_ID_W,
    parameter int DEPTH = c_TAG_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != c_CNT_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_head = r_mem[r_rd_ptr];

endmodule : slice_tag_fifo
`default_nettype wire

// File: rtl/mtrx_slice_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : mtrx_slice_fifo_arb
// Description : Round-robin scheduler sharing one width-converting FIFO
//               (WR_WIDTH in, RD_WIDTH out) among NUM_REQ slice producers.
//               Whole bursts are granted only when word credit guarantees
//               room. The read side serves one byte consumer and tags each
//               byte with its source id and an end-of-burst flag.
// Ports       : s_clk, s_rst (sync, active high; also resets the FIFO)
//               req_valid/req_data       - producers
//               grant                    - one-hot, winner's data sampled
//               fifo_din/wr_en/full/empty/rd_en/dout - data FIFO interface
//               cons_rd_en               - consumer byte request
//               cons_valid/data/src_id/last - tagged byte out
//               err_overflow             - sticky write-while-full flag
// Revision    : 1.0 - initial release
// ============================================================================
module mtrx_slice_fifo_arb
    import mtrx_slice_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = c_NUM_REQ,
    parameter int WR_WIDTH   = c_WR_WIDTH,
    parameter int RD_WIDTH   = c_RD_WIDTH,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int BURST_LEN  = c_BURST_LEN,
    parameter int ID_W       = c_ID_W
) (
    input  logic                        s_clk,
    input  logic                        s_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WR_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic [WR_WIDTH-1:0]         fifo_din,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [RD_WIDTH-1:0]         fifo_dout,
    input  logic                        cons_rd_en,
    output logic                        cons_valid,
    output logic [RD_WIDTH-1:0]         cons_data,
    output logic [ID_W-1:0]             cons_src_id,
    output logic                        cons_last,
    output logic                        err_overflow
);

    localparam int c_RATIO_L     = WR_WIDTH / RD_WIDTH;
    localparam int c_BURST_BYTES = BURST_LEN * c_RATIO_L;
    localparam int c_CREDIT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int c_BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_BYTE_W      = (c_RATIO_L > 1) ? $clog2(c_RATIO_L) : 1;
    localparam int c_BB_W        = (c_BURST_BYTES > 1) ? $clog2(c_BURST_BYTES) : 1;

    localparam logic [c_CREDIT_W-1:0] c_CREDIT_MAX = c_CREDIT_W'(FIFO_DEPTH);
    localparam logic [c_CREDIT_W-1:0] c_CREDIT_BL  = c_CREDIT_W'(BURST_LEN);
    localparam logic [c_CREDIT_W-1:0] c_CREDIT_NET = c_CREDIT_W'(BURST_LEN - 1);
    localparam logic [c_BEAT_W-1:0]   c_BEAT_LAST  = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_BYTE_W-1:0]   c_BYTE_LAST  = c_BYTE_W'(c_RATIO_L - 1);
    localparam logic [c_BB_W-1:0]     c_BB_LAST    = c_BB_W'(c_BURST_BYTES - 1);
    localparam logic [ID_W-1:0]       c_ID_LAST    = ID_W'(NUM_REQ - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_winner;
    logic [c_BEAT_W-1:0]    r_beat;
    logic [c_CREDIT_W-1:0]  r_credit;
    logic [c_BYTE_W-1:0]    r_byte_cnt;
    logic [c_BB_W-1:0]      r_burst_byte_cnt;
    logic                   r_cons_valid;
    logic [ID_W-1:0]        r_cons_src_id;
    logic                   r_cons_last;
    logic                   r_err_overflow;

    logic                   w_pick_found;
    logic [ID_W-1:0]        w_pick;
    logic                   w_start;
    logic                   w_rd_acc;
    logic                   w_word_done;
    logic                   w_burst_done;
    logic [ID_W-1:0]        w_tag_head;

    // Round-robin pick: scan from the highest offset down so the requester
    // closest to r_rr_ptr (cyclically) is the last one written, i.e. wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_pick_found = 1'b1;
                w_pick       = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_start = (r_state == ST_IDLE) && w_pick_found && (r_credit >= c_CREDIT_BL);

    // FSM next-state and burst-side outputs.
    always_comb begin
        w_state_nxt = r_state;
        grant       = '0;
        fifo_wr_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                grant      = NUM_REQ'(1) << r_winner;
                fifo_wr_en = 1'b1;
                if (r_beat == c_BEAT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign fifo_din = req_data[int'(r_winner) * WR_WIDTH +: WR_WIDTH];

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state  <= ST_IDLE;
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_beat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_winner <= w_pick;
                r_rr_ptr <= (w_pick == c_ID_LAST) ? '0 : w_pick + ID_W'(1);
                r_beat   <= '0;
            end else if (r_state == ST_BURST) begin
                r_beat <= r_beat + c_BEAT_W'(1);
            end
        end
    end

    // Read side: a request against an empty FIFO is simply dropped.
    assign w_rd_acc     = cons_rd_en && !fifo_empty;
    assign fifo_rd_en   = w_rd_acc;
    assign w_word_done  = w_rd_acc && (r_byte_cnt == c_BYTE_LAST);
    assign w_burst_done = w_rd_acc && (r_burst_byte_cnt == c_BB_LAST);

    // Credit counts free FIFO words: reserved a whole burst at grant time,
    // returned one word when its last byte leaves the FIFO.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_credit <= c_CREDIT_MAX;
        end else begin
            case ({w_start, w_word_done})
                2'b10:   r_credit <= r_credit - c_CREDIT_BL;
                2'b11:   r_credit <= r_credit - c_CREDIT_NET;
                2'b01:   r_credit <= (r_credit == c_CREDIT_MAX) ? r_credit : r_credit + c_CREDIT_W'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_byte_cnt       <= '0;
            r_burst_byte_cnt <= '0;
            r_cons_valid     <= 1'b0;
            r_cons_src_id    <= '0;
            r_cons_last      <= 1'b0;
            r_err_overflow   <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_byte_cnt       <= w_word_done  ? '0 : r_byte_cnt + c_BYTE_W'(1);
                r_burst_byte_cnt <= w_burst_done ? '0 : r_burst_byte_cnt + c_BB_W'(1);
            end
            r_cons_valid  <= w_rd_acc;
            r_cons_src_id <= w_rd_acc ? w_tag_head : '0;
            r_cons_last   <= w_burst_done;
            if (fifo_wr_en && fifo_full) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    // The FIFO presents the byte one cycle after rd_en, the same cycle the
    // registered tag fields become valid.
    assign cons_valid   = r_cons_valid;
    assign cons_data    = r_cons_valid ? fifo_dout : '0;
    assign cons_src_id  = r_cons_src_id;
    assign cons_last    = r_cons_last;
    assign err_overflow = r_err_overflow;

    slice_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH / BURST_LEN)
    ) u_tag_fifo (
        .clk    (s_clk),
        .rst    (s_rst),
        .i_push (w_start),
        .i_din  (w_pick),
        .i_pop  (w_burst_done),
        .o_head (w_tag_head)
    );

endmodule : mtrx_slice_fifo_arb
`default_nettype wire

// File: tb/tb_mtrx_slice_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtrx_slice_fifo_arb
// Description : Self-checking bench for mtrx_slice_fifo_arb with a behavioural
//               64b-in / 8b-out FIFO and a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtrx_slice_fifo_arb;

    localparam int NR = 4;
    localparam int WW = 64;
    localparam int RW = 8;

    logic              s_clk = 1'b0;
    logic              s_rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*WW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [WW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [RW-1:0]     fifo_dout = '0;
    logic              cons_rd_en = 1'b0;
    logic              cons_valid;
    logic [RW-1:0]     cons_data;
    logic [1:0]        cons_src_id;
    logic              cons_last;
    logic              err_overflow;
    logic              force_full = 1'b0;

    logic [WW-1:0] req_word [NR] = '{64'h0000_0000_1234_5678, 64'hA1A2_A3A4_A5A6_A7A8,
                                     64'hB0B1_B2B3_B4B5_B6B7, 64'hC8C9_CACB_CCCD_CECF};

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) req_data[i*WW +: WW] = req_word[i];
    end

    always #5 s_clk = ~s_clk;

    mtrx_slice_fifo_arb dut (
        .s_clk        (s_clk),
        .s_rst        (s_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .grant        (grant),
        .fifo_din     (fifo_din),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .cons_rd_en   (cons_rd_en),
        .cons_valid   (cons_valid),
        .cons_data    (cons_data),
        .cons_src_id  (cons_src_id),
        .cons_last    (cons_last),
        .err_overflow (err_overflow)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural width-converting FIFO: whole words in, MSB byte out first.
    logic [7:0] mq[$];
    logic       m_empty = 1'b1;
    logic       m_full  = 1'b0;
    assign fifo_empty = m_empty;
    assign fifo_full  = m_full | force_full;

    always @(posedge s_clk) begin
        if (s_rst) begin
            mq.delete();
            fifo_dout <= '0;
        end else begin
            if (fifo_rd_en && mq.size() > 0) fifo_dout <= mq.pop_front();
            if (fifo_wr_en && !m_full)
                for (int b = 0; b < 8; b++) mq.push_back(fifo_din[63-8*b -: 8]);
        end
        m_empty <= (mq.size() == 0);
        m_full  <= (((mq.size() + 7) / 8) >= 16);
    end

    // Scoreboard: expected bytes {last, src, data} queued as each word is written.
    logic [10:0] sb[$];
    logic [10:0] sb_e;
    int          gid_q[$];
    int          start_q[$];
    int          cyc = 0;
    int          n_bursts = 0;
    int          n_wr = 0;
    int          n_cons = 0;
    int          wr_beat = 0;
    int          mon_id;
    logic        prev_wr = 1'b0;

    always @(posedge s_clk) cyc <= cyc + 1;

    always @(negedge s_clk) begin
        if (s_rst) begin
            sb.delete();
            wr_beat = 0;
            prev_wr = 1'b0;
        end else begin
            if (fifo_wr_en) begin
                n_wr++;
                mon_id = -1;
                for (int i = 0; i < NR; i++)
                    if (grant[i]) mon_id = (mon_id == -1) ? i : -2;
                chk("grant_onehot", 64'(mon_id >= 0), 64'd1);
                if (mon_id >= 0) begin
                    chk("fifo_din", fifo_din, req_word[mon_id]);
                    if (!prev_wr) begin
                        n_bursts++;
                        gid_q.push_back(mon_id);
                        start_q.push_back(cyc);
                    end
                    for (int b = 0; b < 8; b++)
                        sb.push_back({(wr_beat == 3 && b == 7), 2'(mon_id), req_word[mon_id][63-8*b -: 8]});
                    wr_beat = (wr_beat + 1) % 4;
                end
            end
            prev_wr = fifo_wr_en;
            if (cons_valid) begin
                n_cons++;
                if (sb.size() == 0) begin
                    chk("byte_without_expectation", 64'd1, 64'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("cons_data", cons_data, sb_e[7:0]);
                    chk("cons_src_id", cons_src_id, sb_e[9:8]);
                    chk("cons_last", cons_last, sb_e[10]);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge s_clk); #1;
        s_rst = 1'b1; req_valid = '0; cons_rd_en = 1'b0;
        repeat (2) @(posedge s_clk);
        #1 s_rst = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        int k;
        for (k = 0; k < 300 && n_bursts < target; k++) @(negedge s_clk);
        if (n_bursts < target) chk("burst_timeout", 64'(n_bursts), 64'(target));
    endtask

    // Hold mask until n more bursts have started, then drop requests and let
    // the last burst complete.
    task automatic run_bursts(input logic [NR-1:0] mask, input int n);
        int target;
        target = n_bursts + n;
        req_valid = mask;
        wait_bursts(target);
        @(posedge s_clk); #1;
        req_valid = '0;
        repeat (6) @(posedge s_clk);
        #1;
    endtask

    task automatic read_bytes(input int n);
        @(posedge s_clk); #1;
        cons_rd_en = 1'b1;
        repeat (n) @(posedge s_clk);
        #1 cons_rd_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        @(posedge s_clk); #1;
        cons_rd_en = 1'b1;
        for (k = 0; k < 400 && !fifo_empty; k++) begin
            @(posedge s_clk); #1;
        end
        if (!fifo_empty) chk("drain_timeout", 64'd0, 64'd1);
        cons_rd_en = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        int cons0;

        repeat (3) @(posedge s_clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_cons_valid", cons_valid, 0);
        chk("rst_cons_data", cons_data, 0);
        chk("rst_err", err_overflow, 0);
        chk("rst_credit", dut.r_credit, 16);
        s_rst = 1'b0;

        // 1: single burst from requester 0, then 32 byte reads
        run_bursts(4'b0001, 1);
        chk("t1_bursts", n_bursts, 1);
        chk("t1_wr_cycles", n_wr, 4);
        chk("t1_gid", gid_q[0], 0);
        chk("t1_credit_after_grant", dut.r_credit, 12);
        cons0 = n_cons;
        drain();
        chk("t1_bytes", n_cons - cons0, 32);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_credit_back", dut.r_credit, 16);

        // 2: all requesting, no reads
        do_reset();
        base = n_bursts; gbase = gid_q.size();
        req_valid = 4'b1111;
        wait_bursts(base + 4);
        repeat (15) @(posedge s_clk);
        #1;
        chk("t2_no_grant_at_credit0", n_bursts, base + 4);
        chk("t2_credit0", dut.r_credit, 0);
        for (int k = 0; k < 4; k++) chk("t2_order", gid_q[gbase+k], k);
        for (int k = 0; k < 3; k++) chk("t2_gap", start_q[gbase+k+1] - start_q[gbase+k], 5);
        read_bytes(31);
        repeat (4) @(posedge s_clk);
        #1;
        chk("t2_no_grant_31_bytes", n_bursts, base + 4);
        read_bytes(1);
        wait_bursts(base + 5);
        @(posedge s_clk); #1;
        req_valid = '0;
        chk("t2_wrap_to_req0", gid_q[gbase+4], 0);
        repeat (6) @(posedge s_clk);
        drain();
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_credit_back", dut.r_credit, 16);

        // 3: reserve and release in the same cycle
        do_reset();
        run_bursts(4'b0001, 3);
        chk("t3_credit4", dut.r_credit, 4);
        read_bytes(7);
        chk("t3_credit_before", dut.r_credit, 4);
        req_valid = 4'b0001;
        cons_rd_en = 1'b1;
        @(posedge s_clk); #1;
        cons_rd_en = 1'b0;
        req_valid = '0;
        chk("t3_credit_net", dut.r_credit, 1);
        repeat (6) @(posedge s_clk);
        drain();
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_credit_back", dut.r_credit, 16);

        // 4: reset in the middle of a burst
        do_reset();
        base = n_bursts;
        req_valid = 4'b0001;
        wait_bursts(base + 1);
        @(posedge s_clk); #1;
        @(posedge s_clk); #1;
        chk("t4_at_beat2_wr_en", fifo_wr_en, 1);
        s_rst = 1'b1;
        req_valid = '0;
        @(posedge s_clk); #1;
        chk("t4_grant", grant, 0);
        chk("t4_wr_en", fifo_wr_en, 0);
        chk("t4_credit", dut.r_credit, 16);
        chk("t4_rr_ptr", dut.r_rr_ptr, 0);
        chk("t4_cons_valid", cons_valid, 0);
        @(posedge s_clk); #1;
        s_rst = 1'b0;

        // 5: read request on an empty FIFO
        @(posedge s_clk); #1;
        cons_rd_en = 1'b1;
        #1;
        chk("t5_rd_en", fifo_rd_en, 0);
        repeat (3) @(posedge s_clk);
        #1;
        chk("t5_cons_valid", cons_valid, 0);
        chk("t5_byte_cnt", dut.r_byte_cnt, 0);
        chk("t5_burst_byte_cnt", dut.r_burst_byte_cnt, 0);
        chk("t5_credit", dut.r_credit, 16);
        cons_rd_en = 1'b0;

        // 6: write while FIFO reports full
        chk("t6_err_before", err_overflow, 0);
        force_full = 1'b1;
        run_bursts(4'b0001, 1);
        chk("t6_err_set", err_overflow, 1);
        force_full = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
        chk("t6_err_sticky", err_overflow, 1);
        cons0 = n_cons;
        drain();
        chk("t6_write_not_suppressed", n_cons - cons0, 32);
        chk("t6_err_still", err_overflow, 1);
        do_reset();
        #1;
        chk("t6_err_cleared", err_overflow, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mtrx_slice_fifo_arb
`default_nettype wire
